// File: rtl/ramb16_s2_pkg.sv
// rtl/ramb16_s2_pkg.sv - shared constants, FSM states and slice type for the RAMB16_S2 byte reader
package ramb16_s2_pkg;

    localparam int ADDR_W          = 13;
    localparam int SLICES_PER_BYTE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [1:0] slice_t;

    localparam slice_t LAST_SLICE = slice_t'(SLICES_PER_BYTE - 1);

endpackage

// File: rtl/ramb16_s2_byte_pack.sv
// rtl/ramb16_s2_byte_pack.sv - captures 2-bit RAM slices into bytes and holds them on a valid/ready output
// Packing order selected by RAMB_S2_RD_MSB_FIRST_EN (undefined: slice 0 lands in the LSBs).
module ramb16_s2_byte_pack
    import ramb16_s2_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rd_en_i,
    input  slice_t     rd_slice_i,
    input  logic [1:0] ram_do_i,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o
);

    logic       cap_vld_q;
    slice_t     cap_slice_q;
    logic [5:0] pack_q, pack_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] byte_w;

`ifdef RAMB_S2_RD_MSB_FIRST_EN
    assign byte_w = {pack_q, ram_do_i};
`else
    assign byte_w = {ram_do_i, pack_q};
`endif

    always_comb begin
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (cap_vld_q) begin
            if (cap_slice_q == LAST_SLICE) begin
                // The reader only issues the last slice once this register is free.
                out_data_d  = byte_w;
                out_valid_d = 1'b1;
            end else begin
`ifdef RAMB_S2_RD_MSB_FIRST_EN
                pack_d = {pack_q[3:0], ram_do_i};
`else
                pack_d = {ram_do_i, pack_q[5:2]};
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_vld_q   <= 1'b0;
            cap_slice_q <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cap_vld_q   <= rd_en_i;
            cap_slice_q <= rd_slice_i;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/ramb16_s2_byte_reader.sv
// rtl/ramb16_s2_byte_reader.sv - burst read sequencer turning 2-bit RAMB16_S2 reads into a byte stream
// Build option RAMB_S2_RD_MSB_FIRST_EN selects big-endian slice packing in the pack stage.
module ramb16_s2_byte_reader #(
    parameter int ADDR_W = ramb16_s2_pkg::ADDR_W,
    parameter int LEN_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-3:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_en_o,
    input  logic [1:0]        ram_do_i,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    import ramb16_s2_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, pend_addr;
    logic              ram_en_q, ram_en_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              slice3_issued;
    logic              out_valid_w;

    // Next slice to issue: advance after a read, repeat the address after a stall.
    assign pend_addr     = ram_en_q ? ram_addr_q + ADDR_W'(1) : ram_addr_q;
    assign slice3_issued = ram_en_q && (slice_t'(ram_addr_q[1:0]) == LAST_SLICE);

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_en_d   = 1'b0;
        len_d      = len_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !busy_q) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        ram_en_d   = 1'b1;
                        ram_addr_d = {base_i, 2'b00};
                        len_d      = len_i;
                    end
                end
            end
            FETCH: begin
                if (slice3_issued && len_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    if (slice3_issued) begin
                        len_d = len_q - LEN_W'(1);
                    end
                    ram_addr_d = pend_addr;
                    // Final slice only goes out when the output register will be free for it.
                    ram_en_d   = (slice_t'(pend_addr[1:0]) != LAST_SLICE) || !out_valid_w || out_ready_i;
                end
            end
            DRAIN: begin
                if (out_valid_w && out_ready_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == DRAIN && done_d);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
            len_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_en_q   <= ram_en_d;
            len_q      <= len_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    ramb16_s2_byte_pack u_pack (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_en_i     (ram_en_q),
        .rd_slice_i  (slice_t'(ram_addr_q[1:0])),
        .ram_do_i    (ram_do_i),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_w)
    );

    assign out_valid_o = out_valid_w;
    assign ram_addr_o  = ram_addr_q;
    assign ram_en_o    = ram_en_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule
